// File: rtl/ble_rx_queue_if.sv
// RX-byte-in / RAM-write-out bundle for ble_rx_queue; master drives the i_* side, slave is the queue.
`timescale 1ns/1ps
interface ble_rx_queue_if #(
   parameter int DEPTH = 16,
   parameter int BITS  = 8
);
   logic [BITS-1:0]          i_rx_dat;
   logic                     i_rx_done;
   logic                     i_cpu_cyc;
   logic                     o_wr_cyc;
   logic [31:0]              o_wr_adr;
   logic [31:0]              o_wr_dat;
   logic [3:0]               o_wr_sel;
   logic                     i_wr_ack;
   logic [$clog2(DEPTH):0]   o_count;
   logic                     o_overflow;
   logic                     i_ovf_clr;

   modport master (
      output i_rx_dat, i_rx_done, i_cpu_cyc, i_wr_ack, i_ovf_clr,
      input  o_wr_cyc, o_wr_adr, o_wr_dat, o_wr_sel, o_count, o_overflow
   );

   modport slave (
      input  i_rx_dat, i_rx_done, i_cpu_cyc, i_wr_ack, i_ovf_clr,
      output o_wr_cyc, o_wr_adr, o_wr_dat, o_wr_sel, o_count, o_overflow
   );
endinterface

// File: rtl/ble_rx_queue.sv
// Byte FIFO draining into a circular 32-bit RAM window; write cycle starts 1 cycle after a byte lands.
// Waits for an idle CPU bus before writing; bytes arriving while full are dropped and flagged sticky.
`timescale 1ns/1ps
module ble_rx_queue #(
   parameter int          DEPTH  = 16,
   parameter int          BITS   = 8,
   parameter logic [31:0] ADR_LL = 32'h00C0_0000,
   parameter logic [31:0] ADR_UL = 32'h00C1_0000
) (
   input  logic          i_wb_clk,
   input  logic          i_wb_rst_n,
   ble_rx_queue_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

   logic [BITS-1:0] mem_q [DEPTH];
   logic [AW-1:0]   wptr_q, rptr_q;
   logic [AW:0]     count_q, count_d;
   logic            ovf_q, ovf_d;
   state_t          state_q, state_d;
   logic            cyc_q, cyc_d;
   logic [31:0]     adr_q, adr_d;
   logic [31:0]     dat_q, dat_d;
   logic [3:0]      sel_q, sel_d;
   logic [31:0]     adr_inc;
   logic            full, push, pop, drop;

   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign full    = (count_q == (AW+1)'(DEPTH));
   assign pop     = (state_q == WRITE) && bus.i_wr_ack;
   assign push    = bus.i_rx_done && (!full || pop);
   assign drop    = bus.i_rx_done && full && !pop;
   assign adr_inc = adr_q + 32'd4;

   assign count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   assign ovf_d   = drop ? 1'b1 : (bus.i_ovf_clr ? 1'b0 : ovf_q);

   always_ff @(posedge i_wb_clk) begin
      if (push) begin
         mem_q[wptr_q] <= bus.i_rx_dat;
      end
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      case (state_q)
         IDLE: begin
            if ((count_q != '0) && !bus.i_cpu_cyc) begin
               state_d = WRITE;
               cyc_d   = 1'b1;
               sel_d   = 4'hF;
               dat_d   = 32'(mem_q[rptr_q]);
            end
         end
         WRITE: begin
            // CPU cyc is not sampled here: the mux stays on the queue until ack.
            if (bus.i_wr_ack) begin
               state_d = IDLE;
               cyc_d   = 1'b0;
               sel_d   = 4'h0;
               adr_d   = (adr_inc == ADR_UL) ? ADR_LL : adr_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
      if (!i_wb_rst_n) begin
         state_q <= IDLE;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         cyc_q   <= 1'b0;
         adr_q   <= ADR_LL;
         dat_q   <= '0;
         sel_q   <= 4'h0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         cyc_q   <= cyc_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
      end
   end

   assign bus.o_wr_cyc   = cyc_q;
   assign bus.o_wr_adr   = adr_q;
   assign bus.o_wr_dat   = dat_q;
   assign bus.o_wr_sel   = sel_q;
   assign bus.o_count    = count_q;
   assign bus.o_overflow = ovf_q;
endmodule
